// File: rtl/mult16_seq_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

  localparam int MULT_WIDTH = 16;
  localparam int MULT_ITERS = MULT_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult16_seq_if.sv
// Operand/result bundle between the control unit (master) and the multiplier (slave).
// Handshake: start is sampled only while the multiplier is not busy (IDLE or DONE);
// busy is high for every iteration cycle, and done pulses for one cycle when
// {product_hi, product} becomes valid; the product then holds until the next result.
interface mult16_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] product_hi;

  modport master (
    output start, A, B,
    input  busy, done, product, product_hi
  );

  modport slave (
    input  start, A, B,
    output busy, done, product, product_hi
  );
endinterface

// File: rtl/mult16_seq_acc_adder.sv
// Ripple-carry accumulator adder, 2*WIDTH bits wide; the final carry out is dropped.
module mult_acc_adder #(
  parameter int WIDTH = 16
) (
  input  logic [2*WIDTH-1:0] a_i,
  input  logic [2*WIDTH-1:0] b_i,
  output logic [2*WIDTH-1:0] sum_o
);

  localparam int SW = 2 * WIDTH;

  logic [SW-1:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < SW; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ carry[i];
    // The top cell computes no carry: the product never exceeds 2*WIDTH bits.
    if (i < SW - 1) begin : g_carry
      assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

endmodule

// File: rtl/mult16_seq.sv
// Unsigned shift-add multiplier, one partial product per cycle.
// Optional MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module mult16_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  mult16_seq_if.slave       bus,
  output state_t            dbg_state_o
);

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [2*WIDTH-1:0]   acc_sum;
  logic                 last_iter;

  mult_acc_adder #(.WIDTH(WIDTH)) u_acc_adder (
    .a_i   (acc_q),
    .b_i   (mcand_q),
    .sum_o (acc_sum)
  );

`ifdef MULT_EARLY_EXIT_EN
  // mplier_q[WIDTH-1:1] is the multiplier after this cycle's shift.
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1)) || (mplier_q[WIDTH-1:1] == '0);
`else
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          mcand_d  = {{WIDTH{1'b0}}, bus.A};
          mplier_d = bus.B;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_sum;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_iter) begin
          prod_d  = mplier_q[0] ? acc_sum : acc_q;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.product    = prod_q[WIDTH-1:0];
  assign bus.product_hi = prod_q[2*WIDTH-1:WIDTH];
  assign dbg_state_o    = state_q;

endmodule
